spart_rx_fifo: RTL

Parametrised SPART receive path: oversampling UART receiver with configurable data width, programmable baud divisor, receive FIFO of configurable depth, and sticky framing and overrun error flags. It sits between the external `rxd` pin and the SPART bus interface. The driver drains received words through a first-word-fall-through read port instead of a single receive buffer.

---
 rtl/spart_rx_fifo_if.sv | 45 ++++
 rtl/spart_rx_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_rx_fifo_if.sv
// spart_rx_fifo_if: bus-side and line-side signals of the SPART receive path.
// The slave modport is the receiver's view; the master modport is the
// driver/host view. With SPART_PARITY_EN defined, the interface also carries
// the parity_odd select.
interface spart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int DIV_W  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DIV_W-1:0]  divisor;
    logic              rxd;
    logic              rd_en;
    logic              clr_err;
`ifdef SPART_PARITY_EN
    logic              parity_odd;
`endif
    logic [DATA_W-1:0] rd_data;
    logic              rda;
    logic [CNT_W-1:0]  count;
    logic              frame_err;
    logic              overrun;
    logic              parity_err;

`ifdef SPART_PARITY_EN
    modport slave (
        input  divisor, rxd, rd_en, clr_err, parity_odd,
        output rd_data, rda, count, frame_err, overrun, parity_err
    );
    modport master (
        output divisor, rxd, rd_en, clr_err, parity_odd,
        input  rd_data, rda, count, frame_err, overrun, parity_err
    );
`else
    modport slave (
        input  divisor, rxd, rd_en, clr_err,
        output rd_data, rda, count, frame_err, overrun, parity_err
    );
    modport master (
        output divisor, rxd, rd_en, clr_err,
        input  rd_data, rda, count, frame_err, overrun, parity_err
    );
`endif
endinterface

// File: rtl/spart_rx_fifo.sv
// spart_rx_fifo: oversampling UART receiver feeding a first-word-fall-through
// receive FIFO, with sticky framing / overrun / parity error flags.
// Optional feature macro: SPART_PARITY_EN adds a parity bit between the data
// and stop bits, checked against bus.parity_odd (0 = even, 1 = odd).
module spart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int OVS    = 16,
    parameter int DIV_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    spart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);
    localparam logic [SW-1:0] SC_MID   = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] SC_END   = SW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

`ifdef SPART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // Line synchroniser and edge history
    logic              r_sync1;
    logic              r_sync2;
    logic              r_rxs_prev;
    logic              w_rxs;

    // Oversample tick generator
    logic [DIV_W-1:0]  r_tcnt;
    logic              w_tick;

    // Receive FSM
    state_t            r_state;
    logic [SW-1:0]     r_sc;
    logic [BW-1:0]     r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_stop_wait;
    logic              r_push;
    logic              r_frame_err;
`ifdef SPART_PARITY_EN
    logic              r_par_bad;
    logic              r_parity_err;
`endif

    // FIFO
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_overrun;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_wr;

    assign w_rxs  = r_sync2;
    assign w_tick = (r_state != S_IDLE) && (r_tcnt == '0);

    // Two-flop synchroniser on rxd plus one history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync1    <= bus.rxd;
            r_sync2    <= r_sync1;
            r_rxs_prev <= r_sync2;
        end
    end

    // Tick down-counter: held loaded with divisor while idle, free-runs during a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (r_state == S_IDLE || r_tcnt == '0) begin
            r_tcnt <= bus.divisor;
        end else begin
            r_tcnt <= r_tcnt - 1'b1;
        end
    end

    // Frame receiver: start qualification, LSB-first shift, parity and stop checks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sc         <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_stop_wait  <= 1'b0;
            r_push       <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef SPART_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_push <= 1'b0;
            // Clear first so that a same-cycle error assignment below wins
            if (bus.clr_err) begin
                r_frame_err  <= 1'b0;
`ifdef SPART_PARITY_EN
                r_parity_err <= 1'b0;
`endif
            end
            case (r_state)
                S_IDLE: begin
                    if (r_rxs_prev && !w_rxs) begin
                        r_state <= S_START;
                        r_sc    <= '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_sc == SC_MID) begin
                            // Line back high at mid-bit: a glitch, not a start bit
                            r_sc    <= '0;
                            r_bit   <= '0;
                            r_state <= w_rxs ? S_IDLE : S_DATA;
                        end else begin
                            r_sc <= r_sc + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_sc == SC_END) begin
                            r_sc    <= '0;
                            r_shift <= {w_rxs, r_shift[DATA_W-1:1]};
                            if (r_bit == BIT_LAST) begin
`ifdef SPART_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end else begin
                            r_sc <= r_sc + 1'b1;
                        end
                    end
                end
`ifdef SPART_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        if (r_sc == SC_END) begin
                            r_sc      <= '0;
                            r_state   <= S_STOP;
                            r_par_bad <= (w_rxs != ((^r_shift) ^ bus.parity_odd));
                            if (w_rxs != ((^r_shift) ^ bus.parity_odd)) begin
                                r_parity_err <= 1'b1;
                            end
                        end else begin
                            r_sc <= r_sc + 1'b1;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (r_stop_wait) begin
                        // Break / bad stop: hold here until the line idles again
                        if (w_rxs) begin
                            r_stop_wait <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end else if (w_tick) begin
                        if (r_sc == SC_END) begin
                            r_sc <= '0;
                            if (w_rxs) begin
`ifdef SPART_PARITY_EN
                                r_push <= !r_par_bad;
`else
                                r_push <= 1'b1;
`endif
                                r_state <= S_IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_stop_wait <= 1'b1;
                            end
                        end else begin
                            r_sc <= r_sc + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = bus.rd_en && !w_empty;
    // A push into a full FIFO still succeeds when the head is popped in the same cycle
    assign w_wr    = r_push && (!w_full || w_pop);

    // FIFO pointers, occupancy and the sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.clr_err) begin
                r_overrun <= 1'b0;
            end
            if (r_push && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // FIFO storage; the received word is still held in the shift register one cycle after the stop sample
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    assign bus.rd_data   = w_empty ? '0 : r_mem[r_rptr];
    assign bus.rda       = !w_empty;
    assign bus.count     = r_count;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
`ifdef SPART_PARITY_EN
    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule
